kbd_event_queue: RTL

Key-event queue between the keyboard code register and the Hack CPU's memory-mapped keyboard read port. Consumes the 16-bit key code the keyboard block presents (0 = no key), filters it for stability, converts each accepted code change into a discrete key event, and buffers the events in a small FIFO. The CPU reads events one at a time, so short presses are never lost between polls.

---
 rtl/kbd_event_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kbd_event_queue.sv
// Debounced key-event queue feeding the Hack CPU keyboard read port.
// Optional build macro KBD_RELEASE_EVENTS_EN adds release events (16'h8000 | code).
module kbd_event_queue #(
  parameter int DEPTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [15:0]              key_code,
  input  logic                     rd_en,
  output logic [15:0]              rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  logic [15:0]   r_sample;
  logic [SW-1:0] r_stab;
  logic [15:0]   r_accepted;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic [15:0]   r_mem [DEPTH];

  logic          w_stable;
  logic          w_change;
  logic          w_accept;
  logic          w_push_req;
  logic [15:0]   w_push_data;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  // Stability filter: stab counts consecutive cycles with key_code == sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sample <= '0;
      r_stab   <= '0;
    end else begin
      r_sample <= key_code;
      if (key_code != r_sample)
        r_stab <= '0;
      else if (r_stab != STAB_MAX)
        r_stab <= r_stab + SW'(1);
    end
  end

  assign w_stable = (r_stab == STAB_MAX);
  assign w_change = (r_sample != r_accepted);

`ifdef KBD_RELEASE_EVENTS_EN
  logic [15:0] r_pend;
  logic        r_pend_valid;
  logic        w_pend_load;

  // A pending press blocks acceptance so release/press ordering is preserved.
  assign w_accept = w_stable && w_change && !r_pend_valid;

  always_comb begin
    w_push_req  = 1'b0;
    w_push_data = '0;
    w_pend_load = 1'b0;
    if (r_pend_valid) begin
      w_push_req  = 1'b1;
      w_push_data = r_pend;
    end else if (w_accept) begin
      w_push_req = 1'b1;
      if (r_accepted != 16'd0) begin
        w_push_data = 16'h8000 | r_accepted;
        w_pend_load = (r_sample != 16'd0);
      end else begin
        w_push_data = r_sample;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
    end else if (r_pend_valid) begin
      r_pend_valid <= 1'b0;
    end else if (w_pend_load) begin
      r_pend       <= r_sample;
      r_pend_valid <= 1'b1;
    end
  end
`else
  assign w_accept = w_stable && w_change;

  always_comb begin
    w_push_req  = 1'b0;
    w_push_data = '0;
    if (w_accept && (r_sample != 16'd0)) begin
      w_push_req  = 1'b1;
      w_push_data = r_sample;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_accepted <= '0;
    else if (w_accept)
      r_accepted <= r_sample;
  end

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = rd_en && !w_empty;
  assign w_push  = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_req && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
  end

  assign rd_data  = w_empty ? 16'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign empty    = w_empty;
  assign count    = r_wr_ptr - r_rd_ptr;
  assign overflow = r_overflow;

endmodule
